// File: rtl/data_org_pkg.sv
// Shared constants, FSM state type and flat-bus slicing helper for the
// channel serializer.
package data_org_pkg;

  localparam int unsigned N_CH  = 64;
  localparam int unsigned W     = 11;
  localparam int unsigned IDX_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Bit offset of channel k inside the flattened channel bus.
  function automatic int unsigned slice_off(input int unsigned k);
    return k * W;
  endfunction

endpackage

// File: rtl/signal_bank.sv
// Snapshot register bank: captures every channel of the flat bus on load
// and returns one word selected by a registered index.
module signal_bank
  import data_org_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [N_CH*W-1:0] flat,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [W-1:0]      rd_data
);

  logic [W-1:0] bank_q [N_CH];
  logic [W-1:0] bank_d [N_CH];

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      bank_d[k] = bank_q[k];
      if (load) begin
        bank_d[k] = flat[slice_off(k) +: W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        bank_q[k] <= bank_d[k];
      end
    end
  end

  assign rd_data = bank_q[rd_idx];

endmodule

// File: rtl/data_serialize.sv
// Frame serializer: snapshots all channels on start and streams them out
// one word per valid/ready handshake, tagged with index and last flag.
module data_serialize
  import data_org_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_CH*W-1:0] signals_flat,
  output logic [W-1:0]      out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next state: start only matters in IDLE; SEND advances on handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  signal_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .flat    (signals_flat),
    .rd_idx  (idx_q),
    .rd_data (out_data)
  );

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_index = idx_q;
  assign out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign done      = done_q;

endmodule
